// File: rtl/lsl_iter_shifter.sv
// Multi-cycle logical shift-left unit: one log-stage per clock, MSB stage first,
// with valid/ready handshakes on the request and result sides.
module lsl_iter_shifter #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic             CLK,
    input  logic             RESETn,
    input  logic             InValid,
    output logic             InReady,
    input  logic [WIDTH-1:0] ShIn,
    input  logic [SHW-1:0]   Shamt,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [WIDTH-1:0] ShOutLSL,
    output logic             Busy
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] data;
    logic [SHW-1:0]   amt;
    logic [SHW-1:0]   stage;
    logic [SHW-1:0]   step;
    logic [WIDTH-1:0] shifted;

    // The single shared stage: shift by 2^stage, stepping from the MSB stage down.
    always_comb begin
        step    = SHW'(1) << stage;
        shifted = data << step;
    end

    // NOTE: every register of this process uses non-blocking assignment so all
    // state updates at an edge see the values from before that edge.
    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            state    <= IDLE;
            data     <= '0;
            amt      <= '0;
            stage    <= '0;
            InReady  <= 1'b1;
            OutValid <= 1'b0;
            Busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (InValid && InReady) begin
                        data    <= ShIn;
                        amt     <= Shamt;
                        stage   <= SHW'(SHW - 1);
                        InReady <= 1'b0;
                        Busy    <= 1'b1;
                        if (Shamt == '0) begin
                            state    <= DONE;
                            OutValid <= 1'b1;
                        end else begin
                            state <= SHIFT;
                        end
                    end
                end

                SHIFT: begin
                    // Zero bits of the amount still spend their cycle.
                    if (amt[stage]) begin
                        data <= shifted;
                    end
                    if (stage == '0) begin
                        state    <= DONE;
                        OutValid <= 1'b1;
                    end else begin
                        stage <= stage - SHW'(1);
                    end
                end

                DONE: begin
                    if (OutReady) begin
                        state    <= IDLE;
                        OutValid <= 1'b0;
                        Busy     <= 1'b0;
                        InReady  <= 1'b1;
                    end
                end

                default: begin
                    state    <= IDLE;
                    InReady  <= 1'b1;
                    OutValid <= 1'b0;
                    Busy     <= 1'b0;
                end
            endcase
        end
    end

    assign ShOutLSL = data;

endmodule

// File: tb/tb_lsl_iter_shifter.sv
// Directed-vector bench for lsl_iter_shifter: table of hand-computed shifts,
// reset/abort and stall sequences, then a model-checked random soak.
module tb_lsl_iter_shifter;

    localparam int WIDTH  = 32;
    localparam int SHW    = 5;
    localparam int BUDGET = 20;

    logic             CLK;
    logic             RESETn;
    logic             InValid;
    logic             InReady;
    logic [WIDTH-1:0] ShIn;
    logic [SHW-1:0]   Shamt;
    logic             OutValid;
    logic             OutReady;
    logic [WIDTH-1:0] ShOutLSL;
    logic             Busy;

    int vectors;
    int miscompares;

    typedef struct {
        logic [WIDTH-1:0] shin;
        logic [SHW-1:0]   shamt;
        int               stall;
        logic [WIDTH-1:0] expect_out;
        int               expect_lat;
    } vec_t;

    vec_t table_v[12];

    lsl_iter_shifter #(
        .WIDTH(WIDTH),
        .SHW  (SHW)
    ) dut (
        .CLK     (CLK),
        .RESETn  (RESETn),
        .InValid (InValid),
        .InReady (InReady),
        .ShIn    (ShIn),
        .Shamt   (Shamt),
        .OutValid(OutValid),
        .OutReady(OutReady),
        .ShOutLSL(ShOutLSL),
        .Busy    (Busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Step one rising edge, then settle past it before driving or sampling.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Full transaction: accept, wait for result with a bounded budget, stall, handshake.
    task automatic run_op(input logic [WIDTH-1:0] shin, input logic [SHW-1:0] shamt,
                          input int stall, input logic [WIDTH-1:0] exp_out, input int exp_lat);
        int lat;
        bit seen;
        check("in_ready_before_accept", WIDTH'(InReady), WIDTH'(1));
        InValid = 1'b1;
        ShIn    = shin;
        Shamt   = shamt;
        tick();
        lat  = 0;
        seen = OutValid;
        while (!seen && lat < BUDGET) begin
            check("busy_in_shift", WIDTH'(Busy), WIDTH'(1));
            // Inputs wander during SHIFT; none of it may reach the result.
            InValid  = 1'($urandom);
            ShIn     = $urandom;
            Shamt    = SHW'($urandom);
            OutReady = 1'($urandom);
            tick();
            lat++;
            seen = OutValid;
        end
        InValid = 1'b0;
        if (!seen) begin
            check("result_timeout", WIDTH'(0), WIDTH'(1));
            OutReady = 1'b0;
            return;
        end
        check("latency", WIDTH'(lat), WIDTH'(exp_lat));
        check("result", ShOutLSL, exp_out);
        OutReady = 1'b0;
        for (int i = 0; i < stall; i++) begin
            tick();
            check("stall_out_valid", WIDTH'(OutValid), WIDTH'(1));
            check("stall_in_ready", WIDTH'(InReady), WIDTH'(0));
            check("stall_result", ShOutLSL, exp_out);
        end
        OutReady = 1'b1;
        tick();
        OutReady = 1'b0;
        check("post_hs_out_valid", WIDTH'(OutValid), WIDTH'(0));
        check("post_hs_in_ready", WIDTH'(InReady), WIDTH'(1));
        check("post_hs_busy", WIDTH'(Busy), WIDTH'(0));
    endtask

    initial begin
        logic [WIDTH-1:0] r_in;
        logic [SHW-1:0]   r_amt;
        bit               leaked;

        vectors     = 0;
        miscompares = 0;

        table_v[0]  = '{32'h0000_0001, 5'd31, 0, 32'h8000_0000, 5};
        table_v[1]  = '{32'hFFFF_FFFF, 5'd16, 0, 32'hFFFF_0000, 5};
        table_v[2]  = '{32'h1234_5678, 5'd4,  0, 32'h2345_6780, 5};
        table_v[3]  = '{32'hDEAD_BEEF, 5'd0,  0, 32'hDEAD_BEEF, 0};
        table_v[4]  = '{32'h0000_00FF, 5'd3,  4, 32'h0000_07F8, 5};
        table_v[5]  = '{32'h0000_0001, 5'd1,  0, 32'h0000_0002, 5};
        table_v[6]  = '{32'h8000_0001, 5'd1,  2, 32'h0000_0002, 5};
        table_v[7]  = '{32'hA5A5_A5A5, 5'd7,  1, 32'hD2D2_D280, 5};
        table_v[8]  = '{32'hCAFE_F00D, 5'd31, 0, 32'h8000_0000, 5};
        table_v[9]  = '{32'h0F0F_0F0F, 5'd8,  3, 32'h0F0F_0F00, 5};
        table_v[10] = '{32'h1234_5678, 5'd15, 0, 32'h2B3C_0000, 5};
        table_v[11] = '{32'hFFFF_FFFF, 5'd30, 1, 32'hC000_0000, 5};

        RESETn   = 1'b0;
        InValid  = 1'b1;
        OutReady = 1'b0;
        ShIn     = 32'h5555_5555;
        Shamt    = 5'd9;
        tick();
        tick();
        check("reset_in_ready", WIDTH'(InReady), WIDTH'(1));
        check("reset_out_valid", WIDTH'(OutValid), WIDTH'(0));
        check("reset_busy", WIDTH'(Busy), WIDTH'(0));
        check("reset_data", ShOutLSL, 32'h0);
        InValid = 1'b0;
        RESETn  = 1'b1;
        tick();
        check("idle_no_accept", WIDTH'(Busy), WIDTH'(0));

        // Table entries run back-to-back: each accept is the cycle after the prior handshake.
        for (int i = 0; i < 12; i++) begin
            run_op(table_v[i].shin, table_v[i].shamt, table_v[i].stall,
                   table_v[i].expect_out, table_v[i].expect_lat);
        end

        // Abort: reset asserted for the third SHIFT edge.
        InValid = 1'b1;
        ShIn    = 32'hA5A5_A5A5;
        Shamt   = 5'd7;
        tick();
        InValid = 1'b0;
        check("abort_busy_after_accept", WIDTH'(Busy), WIDTH'(1));
        tick();
        tick();
        check("abort_partial_data", ShOutLSL, 32'hA5A5_A5A5);
        RESETn = 1'b0;
        tick();
        RESETn = 1'b1;
        check("abort_in_ready", WIDTH'(InReady), WIDTH'(1));
        check("abort_out_valid", WIDTH'(OutValid), WIDTH'(0));
        check("abort_busy", WIDTH'(Busy), WIDTH'(0));
        check("abort_data", ShOutLSL, 32'h0);
        OutReady = 1'b1;
        leaked   = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (OutValid) leaked = 1'b1;
        end
        OutReady = 1'b0;
        check("abort_no_result", WIDTH'(leaked), WIDTH'(0));

        // Reset wins over a request presented at the same edge.
        InValid = 1'b1;
        ShIn    = 32'h0000_0003;
        Shamt   = 5'd0;
        RESETn  = 1'b0;
        tick();
        RESETn  = 1'b1;
        InValid = 1'b0;
        check("reset_beats_accept", WIDTH'(OutValid), WIDTH'(0));

        for (int n = 0; n < 1000; n++) begin
            r_in  = $urandom;
            r_amt = SHW'($urandom);
            run_op(r_in, r_amt, int'($urandom_range(0, 3)), r_in << r_amt, (r_amt == '0) ? 0 : 5);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
